// File: rtl/display_pkg.sv
// Shared types and constants for the signed 7-segment display scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    localparam int IDX_W = 2;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT_0 = 7'b1000000;
    localparam logic [6:0] SEG_DIGIT_1 = 7'b1111001;
    localparam logic [6:0] SEG_DIGIT_2 = 7'b0100100;
    localparam logic [6:0] SEG_DIGIT_3 = 7'b0110000;
    localparam logic [6:0] SEG_DIGIT_4 = 7'b0011001;
    localparam logic [6:0] SEG_DIGIT_5 = 7'b0010010;
    localparam logic [6:0] SEG_DIGIT_6 = 7'b0000010;
    localparam logic [6:0] SEG_DIGIT_7 = 7'b1111000;
    localparam logic [6:0] SEG_DIGIT_8 = 7'b0000000;
    localparam logic [6:0] SEG_DIGIT_9 = 7'b0010000;

    // Double-dabble correction: a nibble of 5 or more would overflow past 9 once doubled.
    function automatic logic [3:0] bcd_add3(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern, with blank and minus overrides.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       minus,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else if (minus) begin
            seg = SEG_MINUS;
        end else begin
            case (digit)
                4'd0:    seg = SEG_DIGIT_0;
                4'd1:    seg = SEG_DIGIT_1;
                4'd2:    seg = SEG_DIGIT_2;
                4'd3:    seg = SEG_DIGIT_3;
                4'd4:    seg = SEG_DIGIT_4;
                4'd5:    seg = SEG_DIGIT_5;
                4'd6:    seg = SEG_DIGIT_6;
                4'd7:    seg = SEG_DIGIT_7;
                4'd8:    seg = SEG_DIGIT_8;
                4'd9:    seg = SEG_DIGIT_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/signed_display_scanner.sv
// Captures a signed byte, converts its magnitude to BCD by shift-and-add-3,
// and time-multiplexes sign/hundreds/tens/units onto a 4-digit display.
module signed_display_scanner
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] value,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    state_t      state;
    logic [2:0]  step;
    logic [7:0]  mag;
    logic [11:0] bcd;
    logic [11:0] bcd_adj;
    logic        conv_sign;

    logic        disp_sign;
    logic [3:0]  disp_hund;
    logic [3:0]  disp_tens;
    logic [3:0]  disp_units;

    logic [CNT_W-1:0] refresh_cnt;
    logic [IDX_W-1:0] idx;

    logic [3:0]  mux_digit;
    logic        mux_blank;
    logic        mux_minus;
    logic [6:0]  dec_seg;

    assign bcd_adj = {bcd_add3(bcd[11:8]), bcd_add3(bcd[7:4]), bcd_add3(bcd[3:0])};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            step       <= 3'd0;
            mag        <= 8'd0;
            bcd        <= 12'd0;
            conv_sign  <= 1'b0;
            disp_sign  <= 1'b0;
            disp_hund  <= 4'd0;
            disp_tens  <= 4'd0;
            disp_units <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        conv_sign <= value[7];
                        mag       <= value[7] ? (8'd0 - value) : value;
                        bcd       <= 12'd0;
                        step      <= 3'd0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd  <= {bcd_adj[10:0], mag[7]};
                    mag  <= {mag[6:0], 1'b0};
                    step <= step + 3'd1;
                    if (step == 3'd7) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    disp_sign  <= conv_sign;
                    disp_hund  <= bcd[11:8];
                    disp_tens  <= bcd[7:4];
                    disp_units <= bcd[3:0];
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Index 3 is the sign position; its digit value is never shown.
    always_comb begin
        mux_digit = disp_units;
        mux_blank = 1'b0;
        mux_minus = 1'b0;
        case (idx)
            2'd0: mux_digit = disp_units;
            2'd1: begin
                mux_digit = disp_tens;
                mux_blank = (disp_hund == 4'd0) && (disp_tens == 4'd0);
            end
            2'd2: begin
                mux_digit = disp_hund;
                mux_blank = (disp_hund == 4'd0);
            end
            2'd3: begin
                mux_digit = 4'd0;
                mux_blank = ~disp_sign;
                mux_minus = disp_sign;
            end
            default: mux_digit = disp_units;
        endcase
    end

    seg7_decoder u_decoder (
        .digit (mux_digit),
        .blank (mux_blank),
        .minus (mux_minus),
        .seg   (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            idx         <= '0;
            an          <= 4'b1111;
            seg         <= SEG_BLANK;
        end else begin
            if (refresh_cnt == CNT_MAX) begin
                refresh_cnt <= '0;
                idx         <= idx + IDX_W'(1);
            end else begin
                refresh_cnt <= refresh_cnt + CNT_W'(1);
            end
            an  <= ~(4'b0001 << idx);
            seg <= dec_seg;
        end
    end

endmodule

// File: tb/tb_signed_display_scanner.sv
// Directed self-checking bench for signed_display_scanner with a short refresh period.
module tb_signed_display_scanner;

    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] MIN = 7'b0111111;
    localparam logic [6:0] D0  = 7'b1000000;
    localparam logic [6:0] D1  = 7'b1111001;
    localparam logic [6:0] D2  = 7'b0100100;
    localparam logic [6:0] D3  = 7'b0110000;
    localparam logic [6:0] D4  = 7'b0011001;
    localparam logic [6:0] D5  = 7'b0010010;
    localparam logic [6:0] D7  = 7'b1111000;
    localparam logic [6:0] D8  = 7'b0000000;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] value;
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;

    int total = 0;
    int bad   = 0;
    int cycles;
    logic [6:0] disp_seg [4];

    signed_display_scanner #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .value (value),
        .busy  (busy),
        .an    (an),
        .seg   (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse load for one edge; returns just after that edge.
    task automatic applyStimulus(input logic [7:0] v);
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic waitConversion(input int start, output int count);
        count = start;
        while (busy && count < 40) begin
            tick();
            if (busy) count++;
        end
    endtask

    task automatic readDisplay();
        int bad_an;
        bad_an = 0;
        for (int i = 0; i < 4; i++) disp_seg[i] = 7'bx;
        for (int i = 0; i < 16; i++) begin
            tick();
            case (an)
                4'b1110: disp_seg[0] = seg;
                4'b1101: disp_seg[1] = seg;
                4'b1011: disp_seg[2] = seg;
                4'b0111: disp_seg[3] = seg;
                default: bad_an++;
            endcase
        end
        checkOutput("an_onehot", bad_an, 0);
    endtask

    task automatic checkDisplay(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                                input logic [6:0] e1, input logic [6:0] e0);
        readDisplay();
        checkOutput({tag, "_sign"}, {25'd0, disp_seg[3]}, {25'd0, e3});
        checkOutput({tag, "_hund"}, {25'd0, disp_seg[2]}, {25'd0, e2});
        checkOutput({tag, "_tens"}, {25'd0, disp_seg[1]}, {25'd0, e1});
        checkOutput({tag, "_units"}, {25'd0, disp_seg[0]}, {25'd0, e0});
    endtask

    task automatic convertAndCheck(input string tag, input logic [7:0] v, input logic [6:0] e3,
                                   input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
        applyStimulus(v);
        waitConversion(1, cycles);
        checkOutput({tag, "_busy_cycles"}, cycles, 9);
        checkDisplay(tag, e3, e2, e1, e0);
    endtask

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        value = 8'd0;
        tick();
        tick();
        checkOutput("reset_busy", {31'd0, busy}, 0);
        checkOutput("reset_an", {28'd0, an}, 32'b1111);
        checkOutput("reset_seg", {25'd0, seg}, {25'd0, BLK});

        rst = 1'b0;
        tick();
        checkOutput("first_an", {28'd0, an}, 32'b1110);
        checkOutput("first_seg", {25'd0, seg}, {25'd0, D0});
        checkDisplay("reset", BLK, BLK, BLK, D0);

        convertAndCheck("p123", 8'h7B, BLK, D1, D2, D3);
        convertAndCheck("m128", 8'h80, MIN, D1, D2, D8);
        convertAndCheck("m5",   8'hFB, MIN, BLK, BLK, D5);
        convertAndCheck("p7",   8'd7,  BLK, BLK, BLK, D7);
        convertAndCheck("p40",  8'd40, BLK, BLK, D4, D0);

        // A second load while busy must be dropped, not queued.
        applyStimulus(8'hFF);
        tick();
        tick();
        applyStimulus(8'd99);
        waitConversion(4, cycles);
        checkOutput("busyload_cycles", cycles, 9);
        checkDisplay("busyload", MIN, BLK, BLK, D1);
        checkOutput("busyload_idle", {31'd0, busy}, 0);

        applyStimulus(8'd100);
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        checkOutput("midrst_busy", {31'd0, busy}, 0);
        checkOutput("midrst_an", {28'd0, an}, 32'b1111);
        rst = 1'b0;
        tick();
        checkOutput("midrst_first_an", {28'd0, an}, 32'b1110);
        checkOutput("midrst_first_seg", {25'd0, seg}, {25'd0, D0});
        checkDisplay("midrst", BLK, BLK, BLK, D0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/signed_display_scanner.md
# signed_display_scanner

Sequential front-end for the board's 4-digit multiplexed 7-segment display. It captures an 8-bit two's-complement value on a load strobe, converts its magnitude to BCD with an 8-step shift-and-add-3 FSM, commits sign and digits to display registers, and continuously time-multiplexes sign, hundreds, tens and units onto shared segment lines. It sits between the arithmetic result registers and the board display pins, replacing the combinational divide/modulo digit split with a small sequential datapath.

## Interface
- REFRESH_DIV, default 50000: clock cycles each digit stays selected; legal range 2..2^20.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- load  in  1  capture request; sampled only in IDLE.
- value  in  8  signed two's-complement number to display.
- busy  out  1  high while a conversion is in progress.
- an  out  4  digit enables, active-low; an[0]=units, an[1]=tens, an[2]=hundreds, an[3]=sign.
- seg  out  7  segments, active-low, ordered {g,f,e,d,c,b,a}.

## Operation
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE: on load=1, latch sign=value[7] and mag=(value[7] ? -value : value) as 8-bit unsigned; clear the 12-bit BCD accumulator; set the step count to 0; go to SHIFT. load=0 keeps the FSM in IDLE.
- SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, mag} left by 1. After step 7 (8 shifts total), go to COMMIT.
- COMMIT: write sign, hundreds, tens and units to the display registers in a single cycle, then return to IDLE.
- load while busy is ignored; there is no queueing.
- The -128 input magnitude is 128 (8-bit unsigned) and displays as "-128".
- Leading-zero blanking:
  - hundreds is blank when it equals 0;
  - tens is blank when hundreds and tens both equal 0;
  - units is always shown;
  - the sign digit shows '-' (7'b0111111) when negative, otherwise it is blank.
- Blank digit pattern is 7'b1111111.
- Digit encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Scanner: runs independently of the FSM and always shows the committed registers, never partial results.
  - A refresh counter runs 0..REFRESH_DIV-1.
  - On wrap, the digit index advances 0→1→2→3→0.
- Reset values:
  - FSM in IDLE, busy=0, step count 0;
  - display registers hold sign=0 and digits 0, so the display reads "   0";
  - refresh counter 0, index 0;
  - an=4'b1111, seg=7'b1111111.

## Timing
- load=1 at edge N (IDLE): busy=1 after edge N. The 8 shifts occur at edges N+1..N+8; COMMIT occurs at edge N+9.
- After edge N+9, the display registers hold the new value and busy=0. busy is high for exactly 9 cycles.
- The earliest next accepted load is at edge N+10.
- an and seg are registered: they reflect the index and display registers with 1-cycle latency. The first valid an/seg appear after the first post-reset edge.
- Exactly one an bit is low at any time after that first edge.
- A commit landing mid-scan takes effect on the next registered seg update; no blanking glitch cycle.
- rst mid-conversion: aborts to IDLE, busy=0, display registers return to the "   0" reset values, scanner restarts at index 0.
- Simultaneous rst and load: rst wins.

## Structure
- Shared package display_pkg holds:
  - the FSM state enum;
  - the SEG_BLANK and SEG_MINUS constants;
  - the digit-to-segment localparams;
  - the digit-index width constant.
- One sub-module, seg7_decoder: combinational, 4-bit digit plus blank and minus flags in, 7-bit active-low pattern out. It is instantiated once, after the index mux.
- The refresh counter width is derived with $clog2(REFRESH_DIV).

## Test plan
- Use REFRESH_DIV=4 for all tests.
- Reset: after rst deasserts, busy=0; the scan yields an=1110 with seg=1000000 (0), and the other three digits show seg=1111111.
- Convert +123: value=8'h7B with load. busy is high for 9 cycles, then the digits read sign blank, 1, 2, 3 (seg 1111111, 1111001, 0100100, 0110000).
- Convert -128: value=8'h80. The display reads "-128": an[3] shows 0111111, then 1111001, 0100100, 0000000.
- Leading-zero blanking: value=-5 (8'hFB) reads "-  5". value=8'd7 shows units only. value=8'd40 reads "  40".
- load during busy: pulse -1 then, 3 cycles later, pulse 99. The display reads "-  1"; busy falls 9 cycles after the first load; 99 is never shown.
- Reset mid-conversion: assert rst at SHIFT step 4 of value=100. busy=0 on the next cycle, the display returns to "   0", and the scan index restarts at an=1110.
